// File: rtl/alu_arbiter_2ch_pkg.sv
// Shared types and constants for the two-channel ALU arbiter.
// The optional ALU_ARB_STATS_EN build adds per-channel grant counters of STATS_W bits.
package alu_arb_pkg;

    localparam int ALU_DW  = 4;
    localparam int ALU_SW  = 3;
    localparam int NUM_CH  = 2;
    localparam int STATS_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/alu_arbiter_2ch_if.sv
// Request/response bundle between the two requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_2ch_if
    import alu_arb_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int SW = ALU_SW
);
    logic [NUM_CH-1:0] req_valid;
    logic [NUM_CH-1:0] req_ready;
    logic [DW-1:0]     req_a0;
    logic [DW-1:0]     req_a1;
    logic [DW-1:0]     req_b0;
    logic [DW-1:0]     req_b1;
    logic [SW-1:0]     req_s0;
    logic [SW-1:0]     req_s1;
    logic [NUM_CH-1:0] rsp_valid;
    logic [DW-1:0]     rsp_y;

    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, req_s0, req_s1,
        input  req_ready, rsp_valid, rsp_y
    );

    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, req_s0, req_s1,
        output req_ready, rsp_valid, rsp_y
    );
endinterface

// File: rtl/alu_arbiter_2ch_rr_arb2.sv
// Combinational 2-way round-robin pick: a lone requester always wins,
// a tie goes to the channel named by prio.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       win
);
    always_comb begin
        win = 1'b0;
        gnt = 2'b00;
        case (valid)
            2'b01: begin
                win = 1'b0;
                gnt = 2'b01;
            end
            2'b10: begin
                win = 1'b1;
                gnt = 2'b10;
            end
            2'b11: begin
                win = prio;
                gnt = prio ? 2'b10 : 2'b01;
            end
            default: begin
                win = 1'b0;
                gnt = 2'b00;
            end
        endcase
    end
endmodule

// File: rtl/alu_arbiter_2ch.sv
// Two-channel round-robin sequencer sharing one combinational ALU; one op per two cycles.
// Define ALU_ARB_STATS_EN to add saturating per-channel grant counters.
module alu_arbiter_2ch
    import alu_arb_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int SW = ALU_SW
) (
    input  logic                clk,
    input  logic                rst,
    alu_arbiter_2ch_if.slave    bus,
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    output logic [SW-1:0]       alu_s,
    input  logic [DW-1:0]       alu_y,
    output logic                busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]  grant_cnt0,
    output logic [STATS_W-1:0]  grant_cnt1
`endif
);
    state_t            state;
    logic              prio;
    logic              gnt_id;
    logic [NUM_CH-1:0] gnt;
    logic              win;
    logic              handshake;
    logic [NUM_CH-1:0] rsp_valid;
    logic [DW-1:0]     rsp_y;

    rr_arb2 u_arb (
        .valid (bus.req_valid),
        .prio  (prio),
        .gnt   (gnt),
        .win   (win)
    );

    assign bus.req_ready = (state == IDLE) ? gnt : '0;
    assign handshake     = |(bus.req_valid & bus.req_ready);
    assign busy          = (state == EXEC);
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_y     = rsp_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            gnt_id    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            rsp_valid <= '0;
            rsp_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= '0;
                    if (handshake) begin
                        alu_a  <= win ? bus.req_a1 : bus.req_a0;
                        alu_b  <= win ? bus.req_b1 : bus.req_b0;
                        alu_s  <= win ? bus.req_s1 : bus.req_s0;
                        gnt_id <= win;
                        prio   <= ~win;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU has had a full cycle on the registered operands
                    rsp_y     <= alu_y;
                    rsp_valid <= gnt_id ? 2'b10 : 2'b01;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (handshake) begin
            if (win) grant_cnt1 <= sat_inc(grant_cnt1);
            else     grant_cnt0 <= sat_inc(grant_cnt0);
        end
    end
`endif
endmodule

// File: tb/tb_alu_arbiter_2ch.sv
// Randomized and directed bench for alu_arbiter_2ch against a transaction-level model.
// Build with ALU_ARB_STATS_EN defined to also cover the grant counters.
module tb_alu_arbiter_2ch;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] alu_a, alu_b, alu_y;
    logic [2:0] alu_s;
    logic       busy;
`ifdef ALU_ARB_STATS_EN
    logic [7:0] grant_cnt0, grant_cnt1;
`endif

    alu_arbiter_2ch_if #(.DW(4), .SW(3)) bus ();

    alu_arbiter_2ch #(.DW(4), .SW(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .alu_a (alu_a),
        .alu_b (alu_b),
        .alu_s (alu_s),
        .alu_y (alu_y),
        .busy  (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    // Shared ALU stand-in: 4-bit add regardless of opcode
    assign alu_y = alu_a + alu_b;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int         due;
        bit         ch;
        logic [3:0] y;
    } rsp_t;

    rsp_t       q[$];
    int         cyc;
    bit         m_busy;
    bit         m_prio;
    logic [3:0] m_a, m_b, m_y;
    logic [2:0] m_s;
    int         m_cnt0, m_cnt1;

    task automatic model_reset();
        q.delete();
        m_busy = 1'b0;
        m_prio = 1'b0;
        m_a = '0; m_b = '0; m_s = '0; m_y = '0;
        m_cnt0 = 0; m_cnt1 = 0;
    endtask

    // One clock cycle: apply inputs, check this cycle's outputs, then account for the coming edge
    task automatic step(input logic [1:0] v,
                        input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] s0,
                        input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] s1);
        logic [1:0] exp_rdy, exp_rv;
        bit         w;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_a0 = a0; bus.req_b0 = b0; bus.req_s0 = s0;
        bus.req_a1 = a1; bus.req_b1 = b1; bus.req_s1 = s1;
        #1;
        if (m_busy || v == 2'b00) exp_rdy = 2'b00;
        else if (v == 2'b11)      exp_rdy = m_prio ? 2'b10 : 2'b01;
        else                      exp_rdy = v;
        exp_rv = 2'b00;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_rv = q[0].ch ? 2'b10 : 2'b01;
            m_y    = q[0].y;
            void'(q.pop_front());
        end
        check("req_ready", bus.req_ready, exp_rdy);
        check("rsp_valid", bus.rsp_valid, exp_rv);
        check("rsp_y", bus.rsp_y, m_y);
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_s", alu_s, m_s);
        check("busy", busy, m_busy);
`ifdef ALU_ARB_STATS_EN
        check("grant_cnt0", grant_cnt0, m_cnt0);
        check("grant_cnt1", grant_cnt1, m_cnt1);
`endif
        m_busy = 1'b0;
        if (exp_rdy != 2'b00) begin
            w   = (exp_rdy == 2'b10);
            m_a = w ? a1 : a0;
            m_b = w ? b1 : b0;
            m_s = w ? s1 : s0;
            q.push_back('{due: cyc + 2, ch: w, y: 4'((m_a + m_b) % 16)});
            m_prio = !w;
            m_busy = 1'b1;
            if (w) m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
            else   m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 4'h0, 4'h0, 3'h0, 4'h0, 4'h0, 3'h0);
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock
    task automatic do_reset();
        @(negedge clk);
        bus.req_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        check("rst_ready", bus.req_ready, 2'b00);
        check("rst_rsp_valid", bus.rsp_valid, 2'b00);
        check("rst_rsp_y", bus.rsp_y, 4'h0);
        check("rst_alu_a", alu_a, 4'h0);
        check("rst_alu_b", alu_b, 4'h0);
        check("rst_alu_s", alu_s, 3'h0);
        check("rst_busy", busy, 1'b0);
`ifdef ALU_ARB_STATS_EN
        check("rst_cnt0", grant_cnt0, 8'd0);
        check("rst_cnt1", grant_cnt1, 8'd0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", bus.req_ready, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 2'b00;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_s0 = '0;
        bus.req_a1 = '0; bus.req_b1 = '0; bus.req_s1 = '0;
        cyc = 0;
        model_reset();
        do_reset();

        // Single channel 0 request
        step(2'b01, 4'b1000, 4'b0110, 3'b000, 4'h0, 4'h0, 3'h0);
        check("single_ready", bus.req_ready, 2'b01);
        idle(1);
        check("single_alu_a", alu_a, 4'b1000);
        check("single_alu_b", alu_b, 4'b0110);
        idle(1);
        check("single_rsp_valid", bus.rsp_valid, 2'b01);
        check("single_rsp_y", bus.rsp_y, 4'b1110);
        idle(1);
        check("single_rsp_once", bus.rsp_valid, 2'b00);

        // Contention: both valid continuously
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(2'b11, 4'b0110, 4'b1010, 3'b001, 4'b1001, 4'b0011, 3'b010);
            if (i == 2) begin
                check("rr_rsp0_valid", bus.rsp_valid, 2'b01);
                check("rr_rsp0_y", bus.rsp_y, 4'b0000);
                check("rr_grant1", bus.req_ready, 2'b10);
            end
            if (i == 4) begin
                check("rr_rsp1_valid", bus.rsp_valid, 2'b10);
                check("rr_rsp1_y", bus.rsp_y, 4'b1100);
                check("rr_grant2", bus.req_ready, 2'b01);
            end
            if (i == 6) begin
                check("rr_rsp2_valid", bus.rsp_valid, 2'b01);
                check("rr_rsp2_y", bus.rsp_y, 4'b0000);
            end
        end
        idle(2);

        // Channel 1 arrives while a channel 0 op is executing
        step(2'b01, 4'h3, 4'h4, 3'h5, 4'h0, 4'h0, 3'h0);
        step(2'b10, 4'h0, 4'h0, 3'h0, 4'h7, 4'h2, 3'h6);
        check("busy_block_ready", bus.req_ready, 2'b00);
        check("busy_block_busy", busy, 1'b1);
        step(2'b11, 4'h1, 4'h1, 3'h1, 4'h7, 4'h2, 3'h6);
        check("busy_then_ch1", bus.req_ready, 2'b10);
        idle(3);

        // Reset while an op is in flight
        step(2'b01, 4'b1100, 4'b0111, 3'b000, 4'h0, 4'h0, 3'h0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("dropped_op_rsp", bus.rsp_valid, 2'b00);
        end
        step(2'b11, 4'h2, 4'h2, 3'h0, 4'h5, 4'h5, 3'h0);
        check("prio_after_rst", bus.req_ready, 2'b01);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(2'($urandom_range(0, 3)),
                 4'($urandom), 4'($urandom), 3'($urandom),
                 4'($urandom), 4'($urandom), 3'($urandom));
        end
        idle(3);

        // Grant counting with saturation
        do_reset();
        while (m_cnt0 < 300 && cyc < 90000) begin
            if (m_cnt0 >= 255) break;
            step(2'b01, 4'($urandom), 4'($urandom), 3'($urandom), 4'h0, 4'h0, 3'h0);
        end
        for (int i = 0; i < 90; i++)
            step(2'b01, 4'($urandom), 4'($urandom), 3'($urandom), 4'h0, 4'h0, 3'h0);
        for (int i = 0; i < 6; i++)
            step(2'b10, 4'h0, 4'h0, 3'h0, 4'($urandom), 4'($urandom), 3'($urandom));
        idle(3);
`ifdef ALU_ARB_STATS_EN
        check("grant_cnt0_sat", grant_cnt0, 8'd255);
        check("grant_cnt1_final", grant_cnt1, 8'd3);
`endif
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter_2ch.md
Name: alu_arbiter_2ch

Overview:
- Two-channel round-robin arbiter and sequencer that shares one combinational 4-bit ALU (operands a, b, opcode s, result y) between two requesters.
- Accepts one operation per handshake and drives the shared ALU from registered operands.
- Captures the result and returns it to the originating channel with a one-cycle response pulse.
- Sits between the requesting datapath blocks and the single ALU instance; it is opcode-agnostic.

Parameters:
- DW, 4, operand/result width
- SW, 3, opcode width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  2  per-channel request valid, bit i = channel i
- req_ready  out  2  per-channel ready; combinational, at most one bit high
- req_a0, req_a1  in  DW each  operand a, channel 0/1
- req_b0, req_b1  in  DW each  operand b, channel 0/1
- req_s0, req_s1  in  SW each  opcode, channel 0/1
- alu_a  out  DW  to shared ALU
- alu_b  out  DW  to shared ALU
- alu_s  out  SW  to shared ALU
- alu_y  in  DW  combinational result from shared ALU
- rsp_valid  out  2  one-cycle response pulse, bit i = channel i
- rsp_y  out  DW  result, valid while any rsp_valid bit is high
- busy  out  1  high in EXEC

Behaviour:
- Reset (async): state=IDLE, prio=0 (channel 0 favoured). alu_a, alu_b, alu_s, rsp_valid, rsp_y all 0. busy=0. Internal gnt_id=0.
- FSM states: IDLE, EXEC.
- IDLE, arbitration:
  - Only one channel valid: that channel wins.
  - Both valid: channel prio wins.
  - req_ready[win]=1; all other ready bits 0. No valid means ready=00.
- IDLE, on handshake (valid&ready):
  - Register a/b/s of the winner into alu_a/alu_b/alu_s; gnt_id<=win.
  - prio<=~win.
  - state<=EXEC.
- EXEC:
  - req_ready=00; busy=1.
  - At the clock edge: rsp_y<=alu_y; rsp_valid<=(1<<gnt_id); state<=IDLE.
- rsp_valid is registered and lasts exactly one cycle. There is no response backpressure.
- Latency: request accepted at edge T; ALU driven during cycle T..T+1; rsp_valid high in the cycle after edge T+1.
- Throughput: one operation per 2 cycles. A new grant may occur in the same IDLE cycle in which rsp_valid is high.
- alu_a/alu_b/alu_s hold their last values in IDLE and change only on a handshake.
- rsp_y holds its last value when rsp_valid=00.
- A requester deasserting valid without a handshake is legal. No state change; prio unchanged.
- Operands are sampled only at the handshake edge. Later input changes do not affect the in-flight operation.
- Arithmetic: the block passes values through unmodified. No width change or sign handling. alu_y is taken as-is.
- Reset mid-EXEC: the operation is dropped and no rsp_valid is produced; all outputs return to reset values immediately.
- Simultaneous request from a channel in the same cycle as its own rsp_valid is legal and is arbitrated normally.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (8 bits each).
  - Each increments on every handshake of its channel and saturates at 255.
  - Both reset to 0 on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_arb_pkg:
  - state typedef {IDLE, EXEC}
  - DW/SW defaults
  - NUM_CH=2
  - STATS_W=8 constant
- One natural sub-module: rr_arb2, a combinational 2-way round-robin pick taking valid[1:0] and prio, returning a grant one-hot and win index.
- prio register, FSM and datapath registers stay in the top module.

Test Plan:
- Bench ALU model: y = (a+b) mod 16 for all s, connected to alu_*.
- Reset: assert rst mid-cycle with no clock -> all outputs 0 immediately; release -> req_ready=00 with no valid.
- Single channel: ch0 valid a=1000 b=0110 s=000 -> req_ready=01 same cycle; alu_a=1000, alu_b=0110, alu_s=000 after the edge; rsp_valid=01 and rsp_y=1110 two edges later for exactly one cycle.
- Contention and round-robin:
  - Both valid continuously: ch0 a=0110 b=1010 s=001; ch1 a=1001 b=0011 s=010.
  - Grants alternate ch0, ch1, ch0.
  - Responses are rsp_valid 01/rsp_y=0000, then 10/1100, then 01/0000.
  - One response every 2 cycles.
- Busy block: ch1 raises valid during EXEC of a ch0 op -> req_ready stays 00 until IDLE, then ch1 is granted with prio=1.
- Reset mid-op: rst during EXEC after ch0 handshake (a=1100 b=0111) -> no rsp_valid ever for that op; prio=0 after release.
- ALU_ARB_STATS_EN: 300 ch0 handshakes and 3 ch1 handshakes -> grant_cnt0=255 (saturated), grant_cnt1=3.
